bin_digit_conv: RTL and testbench
=================================

BIN_DIGIT_CONV -- requirements
Module: bin_digit_conv

Interface
REQ-001 Parameter IN_W, default 10: width of the binary input; legal range is IN_W >= 1.
REQ-002 Parameter NDIG, default 6: number of 4-bit output digits; legal range is NDIG >= 1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request a conversion; sampled only in IDLE.
REQ-006 Port mode, input, 2 bits: 0 = per-bit binary, 1 = decimal BCD, 2 = hex, 3 = blank.
REQ-007 Port binary, input, IN_W bits: the operand, sampled with start.
REQ-008 Port digits, output, 4*NDIG bits: registered result; digit 0 (rightmost display) occupies [3:0], digit i occupies [4i+3:4i].
REQ-009 Port overflow, output, 1 bit: registered; 1 = value not fully representable in NDIG digits.
REQ-010 Port busy, output, 1 bit: 1 whenever state != IDLE.
REQ-011 Port done, output, 1 bit: single-cycle pulse when digits/overflow update.

Function
REQ-012 The FSM SHALL have states IDLE, CONV and FIN, with state, counter and scratch updated on clk rising edges only.
REQ-013 In IDLE, when start=1 at edge E0, the block SHALL latch binary and mode and clear the scratch and bit counter.
- At E0, mode 1 SHALL transition IDLE->CONV.
- At E0, modes 0, 2 and 3 SHALL transition IDLE->FIN.
REQ-014 CONV SHALL run double-dabble MSB-first, one bit per edge on edges E1..E_IN_W.
- Per edge: add 3 to each BCD digit >= 5, then shift left one bit, inserting the next operand bit.
- The transition CONV->FIN SHALL occur on the edge that consumes the last bit (counter == IN_W-1).
REQ-015 The BCD scratch SHALL be exactly 4*NDIG bits wide.
- A 1 shifted out of the top digit SHALL set a sticky overflow flag for the current conversion.
- The retained digits SHALL equal value mod 10^NDIG.
REQ-016 On the edge leaving FIN, the block SHALL load digits and overflow, assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency:
- Modes 0, 2 and 3: done=1 in the cycle after E1.
- Mode 1: done=1 in the cycle after E_(IN_W+1).
- busy SHALL be 1 from the cycle after E0 until done is asserted.
REQ-018 Mode 0 results:
- digit i = {3'b0, binary[i]} for i < min(NDIG, IN_W); all other digits = 0.
- overflow = OR of binary bits at index >= NDIG.
REQ-019 Mode 2 results:
- digit i = binary nibble i, zero-extended above IN_W.
- overflow = OR of binary bits at index >= 4*NDIG.
REQ-020 Mode 3 results: all digits SHALL be 4'hF (blank code) and overflow SHALL be 0.
REQ-021 start SHALL be ignored in CONV and FIN, including on the FIN->IDLE edge.
- A start held high SHALL produce back-to-back conversions, each accepted in IDLE.
REQ-022 Changes to binary or mode after E0 SHALL NOT affect the result in progress.
REQ-023 digits and overflow SHALL hold their values between FIN loads; done=0 at all other times.

Reset
REQ-024 When reset=1 at a clk edge, the block SHALL force the FIN state-independent reset values at that edge, regardless of current state (including mid-CONV):
- state = IDLE;
- digits = 0, overflow = 0, busy = 0, done = 0;
- scratch and counter = 0.
REQ-025 reset SHALL take priority over start on the same edge; no done pulse SHALL follow an aborted conversion.

Verification
REQ-026 Reset abort: start mode 1, binary=1023, then reset at E4 -> busy=0, done=0, digits=0, overflow=0; no done in the next 15 cycles.
REQ-027 Mode 0, binary=10'b1000101101 -> done after E1, digits=24'h101101, overflow=1.
REQ-028 Mode 1, binary=1023 -> busy high for 11 cycles, done after E11, digits=24'h001023, overflow=0.
REQ-029 Mode 2, binary=10'h3A7 -> digits=24'h0003A7, overflow=0, done after E1; mode 3 -> digits=24'hFFFFFF.
REQ-030 Continuous start=1, binary toggled every cycle -> one done per conversion; each result matches binary at its E0; no start accepted while busy.
REQ-031 IN_W=20, NDIG=4, mode 1, binary=123456 -> digits=16'h3456, overflow=1, done after E21.

Source files
------------

// File: rtl/bin_digit_conv.sv
// Binary-to-digit converter: per-bit, BCD (sequential double-dabble), hex or blank
// display codes, with a registered result, overflow flag and one-cycle done pulse.
module bin_digit_conv #(
    parameter int IN_W = 10,
    parameter int NDIG = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [IN_W-1:0]   binary,
    output logic [4*NDIG-1:0] digits,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    localparam int DW    = 4 * NDIG;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int EXT_W = IN_W + DW;

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;
    typedef enum logic [1:0] {MODE_BIN, MODE_BCD, MODE_HEX, MODE_BLANK} mode_t;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [DW-1:0]      scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [DW-1:0]      digits_q, digits_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [DW-1:0]      adj;
    logic [EXT_W-1:0]   bin_ext;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational process.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_BIN;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        adj = scratch_q;
        for (int i = 0; i < NDIG; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        bin_ext = EXT_W'(bin_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode_t'(mode);
                    bin_d     = binary;
                    scratch_d = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = (mode == MODE_BCD) ? CONV : FIN;
                end
            end
            CONV: begin
                // The operand is shifted out MSB-first; a carry out of the top
                // digit means the value no longer fits and is remembered.
                scratch_d = {adj[DW-2:0], bin_q[IN_W-1]};
                ovf_d     = ovf_q | adj[DW-1];
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_W - 1)) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                case (mode_q)
                    MODE_BIN: begin
                        digits_d = '0;
                        for (int i = 0; i < NDIG; i++) digits_d[4*i] = bin_ext[i];
                        overflow_d = |(bin_ext >> NDIG);
                    end
                    MODE_BCD: begin
                        digits_d   = scratch_q;
                        overflow_d = ovf_q;
                    end
                    MODE_HEX: begin
                        digits_d   = bin_ext[DW-1:0];
                        overflow_d = |(bin_ext >> DW);
                    end
                    default: begin
                        digits_d   = {NDIG{4'hF}};
                        overflow_d = 1'b0;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    assign digits   = digits_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_bin_digit_conv.sv
// Scoreboard bench for bin_digit_conv: expected results are queued at start and
// compared (value and completion cycle) whenever the DUT pulses done.
module tb_bin_digit_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [1:0]  mode;
    logic [9:0]  binary;
    logic [23:0] digits;
    logic        overflow, busy, done;

    logic        start2;
    logic [1:0]  mode2;
    logic [19:0] bin2;
    logic [15:0] digits2;
    logic        ovf2, busy2, done2;

    bin_digit_conv #(.IN_W(10), .NDIG(6)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .binary(binary),
        .digits(digits), .overflow(overflow), .busy(busy), .done(done)
    );

    bin_digit_conv #(.IN_W(20), .NDIG(4)) dut_wide (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2), .binary(bin2),
        .digits(digits2), .overflow(ovf2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [23:0] digits;
        logic        ovf;
        int          done_cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference result {overflow, digits} for the default 10-bit / 6-digit configuration.
    function automatic logic [24:0] model(input logic [1:0] m, input logic [9:0] b);
        logic [23:0] d;
        logic        o;
        int          v;
        d = '0;
        o = 1'b0;
        case (m)
            2'd0: begin
                for (int i = 0; i < 6; i++) d[4*i] = b[i];
                o = |b[9:6];
            end
            2'd1: begin
                v = int'(b);
                for (int i = 0; i < 6; i++) begin
                    d[4*i +: 4] = 4'(v % 10);
                    v = v / 10;
                end
                o = (v != 0);
            end
            2'd2: d = {14'b0, b};
            default: d = {6{4'hF}};
        endcase
        return {o, d};
    endfunction

    // Called at the negedge preceding the accepting edge E0.
    task automatic push(input string tag, input logic [1:0] m, input logic [23:0] d, input logic o);
        exp_t e;
        e.digits   = d;
        e.ovf      = o;
        e.done_cyc = cyc + 1 + ((m == 2'd1) ? 11 : 1);
        e.tag      = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_digits"}, 64'(digits), 64'(e.digits));
                check({e.tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
                check({e.tag, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
                check({e.tag, "_busy_at_done"}, 64'(busy), 64'd0);
            end
        end
    end

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Single conversion; operand and mode are scrambled right after E0.
    task automatic run_conv(input string tag, input logic [1:0] m, input logic [9:0] b,
                            input logic [23:0] d, input logic o);
        @(negedge clk);
        start = 1'b1; mode = m; binary = b;
        push(tag, m, d, o);
        @(negedge clk);
        start = 1'b0; binary = ~b; mode = m ^ 2'b01;
        wait_drain(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] r;
        int          busy_cnt;
        int          done_cnt;
        int          e0;
        logic        seen;

        reset = 1'b1; start = 1'b0; mode = 2'd0; binary = '0;
        start2 = 1'b0; mode2 = 2'd0; bin2 = '0;
        repeat (2) @(negedge clk);
        check("reset_digits", 64'(digits), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        run_conv("bin_1000101101", 2'd0, 10'b1000101101, 24'h101101, 1'b1);
        run_conv("hex_3A7", 2'd2, 10'h3A7, 24'h0003A7, 1'b0);
        run_conv("blank", 2'd3, 10'h155, 24'hFFFFFF, 1'b0);
        run_conv("bcd_0", 2'd1, 10'd0, 24'h000000, 1'b0);
        run_conv("bcd_999", 2'd1, 10'd999, 24'h000999, 1'b0);
        run_conv("bin_3F", 2'd0, 10'h03F, 24'h111111, 1'b0);

        // BCD 1023 with busy-duration measurement.
        @(negedge clk);
        start = 1'b1; mode = 2'd1; binary = 10'd1023;
        push("bcd_1023", 2'd1, 24'h001023, 1'b0);
        @(negedge clk);
        start = 1'b0; binary = 10'd0; mode = 2'd3;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("bcd_1023_busy_cycles", 64'(busy_cnt), 64'd11);
        wait_drain("bcd_1023");

        for (int k = 0; k < 4; k++) begin
            binary = 10'($urandom_range(0, 1023));
            r = model(2'd1, binary);
            run_conv($sformatf("bcd_rand%0d", k), 2'd1, binary, r[23:0], r[24]);
        end

        // Reset lands on E4 of a BCD conversion.
        @(negedge clk);
        start = 1'b1; mode = 2'd1; binary = 10'd1023;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_digits", 64'(digits), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // Start held high, operand changing every cycle (hex then BCD).
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            start = 1'b1; mode = 2'd2; binary = 10'($urandom_range(0, 1023));
            if (n % 2 == 0) begin
                r = model(2'd2, binary);
                push($sformatf("cont_hex%0d", n / 2), 2'd2, r[23:0], r[24]);
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain("cont_hex");

        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            start = 1'b1; mode = 2'd1; binary = 10'($urandom_range(0, 1023));
            if (n % 12 == 0) begin
                r = model(2'd1, binary);
                push($sformatf("cont_bcd%0d", n / 12), 2'd1, r[23:0], r[24]);
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain("cont_bcd");

        // Wide configuration: 123456 in four BCD digits.
        @(negedge clk);
        start2 = 1'b1; mode2 = 2'd1; bin2 = 20'd123456;
        e0 = cyc + 1;
        @(negedge clk);
        start2 = 1'b0; bin2 = 20'd0; mode2 = 2'd0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done2) seen = 1'b1;
            else @(negedge clk);
        end
        check("wide_done_seen", 64'(seen), 64'd1);
        check("wide_done_cycle", 64'(cyc), 64'(e0 + 21));
        check("wide_digits", 64'(digits2), 64'h3456);
        check("wide_ovf", 64'(ovf2), 64'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
